// File: rtl/muldiv_ctrl.sv
// Iterative MULTU/DIVU sequencer feeding the 64-bit HiLo register.
// It runs a 32-step shift-add multiply or a restoring divide. The result
// {hi,lo} appears on ans together with a single-cycle hilo_we strobe.
// busy/stall hold the pipeline until HiLo is current.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic               mf_req,
  output logic [2*WIDTH-1:0] ans,
  output logic               hilo_we,
  output logic               busy,
  output logic               stall
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  // The multiply adds the multiplicand. The divide subtracts the divisor.
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  // Multiply: {partial product hi, multiplier bits still to consume}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   ans_q, ans_d;

  // One shift-add step. The add carries into bit WIDTH, and that carry
  // is shifted straight back down into the upper half.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;

  // One restoring step. The remainder is always below the divisor, so it
  // fits WIDTH bits. Only the trial subtraction needs the extra bit.
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_diff;
  logic [2*WIDTH-1:0]   div_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;
  assign div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]),
                      acc_q[WIDTH-2:0], div_ge};

  // State, counter, operand, accumulator and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      ans_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      ans_q   <= ans_d;
    end
  end

  // Next-state logic: accept requests in IDLE and step the datapath in MUL/DIV
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    ans_d   = ans_q;
    unique case (state_q)
      IDLE: begin
        if (start && op == OP_MULTU) begin
          opnd_d  = src_a;
          acc_d   = {{WIDTH{1'b0}}, src_b};
          cnt_d   = '0;
          state_d = MUL;
        end else if (start && op == OP_DIVU) begin
          if (src_b != '0) begin
            opnd_d  = src_b;
            acc_d   = {{WIDTH{1'b0}}, src_a};
            cnt_d   = '0;
            state_d = DIV;
          end else begin
            // Divide by zero: the remainder is the dividend and the quotient is all-ones.
            ans_d   = {src_a, {WIDTH{1'b1}}};
            state_d = DONE;
          end
        end
      end
      MUL: begin
        acc_d = mul_next;
        if (cnt_q == LAST_STEP) begin
          ans_d   = mul_next;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DIV: begin
        acc_d = div_next;
        if (cnt_q == LAST_STEP) begin
          ans_d   = div_next;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // A start seen here is refused. Decode keeps it stalled, and it is taken next cycle in IDLE.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ans     = ans_q;
  assign hilo_we = (state_q == DONE);
  assign busy    = (state_q != IDLE);
  assign stall   = busy & (start | mf_req);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl. Cycle 0 is the cycle whose closing edge
// samples start. The helper tasks leave the bench 1 ns after an edge.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mf_req;
  logic [63:0] ans;
  logic        hilo_we;
  logic        busy;
  logic        stall;

  int tests = 0;
  int fails = 0;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .mf_req  (mf_req),
    .ans     (ans),
    .hilo_we (hilo_we),
    .busy    (busy),
    .stall   (stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge. On return the bench is in cycle 1.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    tick();
    start = 1'b0;
    op    = 2'b00;
  endtask

  // Starting in cycle 1, check busy and no strobe through cycle 32, then stop in cycle 33.
  task automatic run_to_done(input string tag);
    logic early;
    logic idle_seen;
    early     = 1'b0;
    idle_seen = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      if (hilo_we) early = 1'b1;
      if (!busy) idle_seen = 1'b1;
      tick();
    end
    check({tag, " no early hilo_we"}, {63'd0, early}, 64'd0);
    check({tag, " busy cycles 1-32"}, {63'd0, idle_seen}, 64'd0);
  endtask

  initial begin
    logic any_we;
    reset  = 1'b1;
    start  = 1'b0;
    op     = 2'b00;
    src_a  = '0;
    src_b  = '0;
    mf_req = 1'b1;
    #2;
    check("reset ans", ans, 64'd0);
    check("reset hilo_we", {63'd0, hilo_we}, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset stall", {63'd0, stall}, 64'd0);
    mf_req = 1'b0;
    #10 reset = 1'b0;
    tick();

    // MULTU 0xFFFFFFFF x 0xFFFFFFFF
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mul max ans hidden cycle1", ans, 64'd0);
    run_to_done("mul max");
    check("mul max hilo_we c33", {63'd0, hilo_we}, 64'd1);
    check("mul max busy c33", {63'd0, busy}, 64'd1);
    check("mul max ans", ans, 64'hFFFF_FFFE_0000_0001);
    tick();
    check("mul max busy c34", {63'd0, busy}, 64'd0);
    check("mul max hilo_we c34", {63'd0, hilo_we}, 64'd0);
    check("mul max ans held", ans, 64'hFFFF_FFFE_0000_0001);

    // DIVU 100 / 7
    issue(2'b10, 32'd100, 32'd7);
    run_to_done("div 100/7");
    check("div 100/7 hilo_we", {63'd0, hilo_we}, 64'd1);
    check("div 100/7 ans", ans, 64'h0000_0002_0000_000E);
    tick();
    check("div 100/7 single strobe", {63'd0, hilo_we}, 64'd0);

    // DIVU 0xFFFFFFFF / 1
    issue(2'b10, 32'hFFFF_FFFF, 32'd1);
    run_to_done("div max/1");
    check("div max/1 ans", ans, 64'h0000_0000_FFFF_FFFF);
    tick();

    // DIVU 0xFFFFFFFF / 0x10000
    issue(2'b10, 32'hFFFF_FFFF, 32'h0001_0000);
    run_to_done("div max/64k");
    check("div max/64k ans", ans, 64'h0000_FFFF_0000_FFFF);
    tick();

    // MULTU 0x10000 x 0x10000, which carries into hi
    issue(2'b01, 32'h0001_0000, 32'h0001_0000);
    run_to_done("mul 64k^2");
    check("mul 64k^2 ans", ans, 64'h0000_0001_0000_0000);
    tick();

    // DIVU 5 / 0: DONE in cycle 1
    issue(2'b10, 32'd5, 32'd0);
    check("div0 hilo_we c1", {63'd0, hilo_we}, 64'd1);
    check("div0 busy c1", {63'd0, busy}, 64'd1);
    check("div0 ans", ans, 64'h0000_0005_FFFF_FFFF);
    tick();
    check("div0 busy c2", {63'd0, busy}, 64'd0);
    check("div0 hilo_we c2", {63'd0, hilo_we}, 64'd0);

    // MULTU 3x4, then a second MULTU 9x9 in cycle 5 that must be refused
    issue(2'b01, 32'd3, 32'd4);
    repeat (4) tick();                        // now in cycle 5
    start = 1'b1; op = 2'b01; src_a = 32'd9; src_b = 32'd9;
    #1;
    check("busy start stall c5", {63'd0, stall}, 64'd1);
    tick();                                   // cycle 6
    start = 1'b0; op = 2'b00;
    #1;
    check("stall drops c6", {63'd0, stall}, 64'd0);
    repeat (27) tick();                       // cycle 33
    mf_req = 1'b1;
    #1;
    check("mf stall in DONE", {63'd0, stall}, 64'd1);
    check("3x4 hilo_we c33", {63'd0, hilo_we}, 64'd1);
    check("3x4 ans", ans, 64'h0000_0000_0000_000C);
    tick();                                   // cycle 34
    check("mf no stall idle", {63'd0, stall}, 64'd0);
    check("9x9 ignored busy", {63'd0, busy}, 64'd0);
    mf_req = 1'b0;
    any_we = 1'b0;
    repeat (40) begin
      if (hilo_we || busy) any_we = 1'b1;
      tick();
    end
    check("9x9 never ran", {63'd0, any_we}, 64'd0);
    check("3x4 ans still held", ans, 64'h0000_0000_0000_000C);

    // Asynchronous reset in the middle of cycle 10 of a MULTU
    issue(2'b01, 32'd7, 32'd7);
    repeat (9) tick();                        // cycle 10
    #3 reset = 1'b1;
    #1;
    check("async rst busy", {63'd0, busy}, 64'd0);
    check("async rst ans", ans, 64'd0);
    check("async rst hilo_we", {63'd0, hilo_we}, 64'd0);
    #2 reset = 1'b0;
    any_we = 1'b0;
    repeat (40) begin
      if (hilo_we) any_we = 1'b1;
      tick();
    end
    check("aborted op no hilo_we", {63'd0, any_we}, 64'd0);
    check("aborted op ans still 0", ans, 64'd0);
    issue(2'b01, 32'd2, 32'd3);
    run_to_done("mul 2x3");
    check("mul 2x3 hilo_we", {63'd0, hilo_we}, 64'd1);
    check("mul 2x3 ans", ans, 64'd6);
    tick();

    // No-op codes: a start with op 11 or 00 is ignored
    issue(2'b11, 32'd8, 32'd8);
    check("op11 busy", {63'd0, busy}, 64'd0);
    issue(2'b00, 32'd8, 32'd8);
    check("op00 busy", {63'd0, busy}, 64'd0);
    any_we = 1'b0;
    repeat (40) begin
      if (hilo_we || busy) any_we = 1'b1;
      tick();
    end
    check("noop no activity", {63'd0, any_we}, 64'd0);
    check("noop ans unchanged", ans, 64'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer that feeds the 64-bit HiLo register.
- Accepts MULTU/DIVU requests from decode and runs a 32-step shift-add multiply or restoring divide.
- Presents the 64-bit result {hi,lo} on ans with a one-cycle write strobe for HiLo.
- Raises busy/stall so the pipeline holds on a new mul/div or an MFHI/MFLO until HiLo is current.

Parameters:
- WIDTH, 32, operand width; result width is 2*WIDTH; iteration count is WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request strobe, sampled on the clk rising edge
- op  input  2  01=MULTU, 10=DIVU; 00 and 11 are no-op (start ignored)
- src_a  input  WIDTH  multiplicand / dividend (unsigned)
- src_b  input  WIDTH  multiplier / divisor (unsigned)
- mf_req  input  1  decode holds an MFHI/MFLO this cycle
- ans  output  2*WIDTH  result {hi,lo}; connects to HiLo Ans
- hilo_we  output  1  one-cycle pulse: ans is valid, HiLo must capture
- busy  output  1  operation in flight
- stall  output  1  pipeline hold request

Behaviour:
- Clock/reset: one clock clk; reset is asynchronous, active-high.
- Reset values: state=IDLE, cnt=0, ans=0, hilo_we=0, busy=0, stall=0.
- Reset asserted mid-operation aborts the operation immediately. No hilo_we is issued for the aborted op.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start=1 with op=01: latch operands, clear accumulator, cnt=0, go to MUL.
  - start=1 with op=10 and src_b!=0: latch operands, cnt=0, go to DIV.
  - start=1 with op=10 and src_b==0: load ans={src_a, all-ones}, go directly to DONE.
  - Any other case: stay in IDLE.
- MUL: one shift-add step per cycle on the unsigned WIDTH x WIDTH product. When cnt==WIDTH-1, go to DONE with ans=full 2*WIDTH product; otherwise cnt+1.
- DIV: one restoring step per cycle. When cnt==WIDTH-1, go to DONE with ans={remainder, quotient} (hi=remainder, lo=quotient).
- DONE: hilo_we=1 for exactly this cycle, then go to IDLE. ans holds its value until the next DONE or reset.
- Latency:
  - start sampled in cycle 0 → MUL/DIV in cycles 1..WIDTH → DONE in cycle WIDTH+1 (cycle 33 at default).
  - Divide-by-zero: DONE in cycle 1.
- busy=1 in MUL, DIV and DONE; 0 in IDLE.
- start while busy=1 is ignored. Operands and op are not latched, and decode must keep it stalled.
- stall (combinational) = busy & (start | mf_req).
  - An MFHI/MFLO during the DONE cycle stalls one more cycle, so it reads HiLo after capture.
- Arithmetic: unsigned only. Internal accumulator is 2*WIDTH+1 bits where needed. No overflow indication.
- ans changes only on entry to DONE or on reset. Intermediate accumulator values are never visible on ans.
- Simultaneous events:
  - reset dominates everything.
  - In DONE, a start request is not accepted. It is accepted on the next cycle, in IDLE.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, start in cycle 0 → cycle 33: hilo_we=1, ans=0xFFFFFFFE_00000001; busy=1 in cycles 1–33, 0 in cycle 34.
- DIVU 100 / 7 → cycle 33: ans=0x00000002_0000000E, single-cycle hilo_we; also DIVU 0xFFFFFFFF/1 → ans=0x00000000_FFFFFFFF.
- DIVU 5 / 0 → cycle 1: hilo_we=1, ans=0x00000005_FFFFFFFF; busy back to 0 in cycle 2.
- MULTU 3×4 started, then MULTU 9×9 with start=1 in cycle 5 → stall=1 in cycle 5; second request ignored; cycle 33 ans=0x00000000_0000000C; mf_req=1 in cycle 33 → stall=1.
- Reset pulsed asynchronously mid-cycle 10 of a MULTU → ans=0, busy=0, hilo_we never pulses; a new MULTU 2×3 afterwards yields ans=6 after 33 cycles.
- op=11 or op=00 with start=1 → stays IDLE, busy=0, no hilo_we.
